// File: rtl/fifo_ctrl.sv
// Pointer/status controller turning a dual-port register file into a synchronous FIFO.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_CTRL_ERR_EN.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic                  i_rd,
`ifdef FIFO_CTRL_ERR_EN
    input  logic                  i_err_clr,
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic                  o_w_en,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
);

    localparam int                  DEPTH_I = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL  = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic                  rd_ok;
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   count_next;

    // A pop on full frees the head slot, so a simultaneous push may land there.
    // Reset masks the write strobe so no register-file entry is touched during it.
    always_comb begin
        rd_ok = i_rd & ~o_empty;
        wr_ok = i_wr & (~o_full | i_rd) & ~i_reset;
    end

    always_comb begin
        count_next = o_count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = o_count + CNT_ONE;
            2'b01:   count_next = o_count - CNT_ONE;
            default: count_next = o_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            w_ptr          <= '0;
            r_ptr          <= '0;
            o_count        <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + PTR_ONE;
            if (rd_ok) r_ptr <= r_ptr + PTR_ONE;
            o_count        <= count_next;
            o_full         <= (count_next == DEPTH);
            o_empty        <= (count_next == '0);
            o_almost_full  <= (count_next >= AF_LVL);
            o_almost_empty <= (count_next <= AE_LVL);
        end
    end

    always_comb begin
        o_w_en   = wr_ok;
        o_w_addr = w_ptr;
        o_r_addr = r_ptr;
    end

`ifdef FIFO_CTRL_ERR_EN
    // A set event in the same cycle as i_err_clr wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= (i_wr & ~wr_ok) | (o_overflow  & ~i_err_clr);
            o_underflow <= (i_rd & ~rd_ok) | (o_underflow & ~i_err_clr);
        end
    end
`else
    // Dropped pushes and ignored pops are silent in this build.
`endif

endmodule
